// File: rtl/ofdm_pkg.sv
// Shared OFDM RX definitions: preamble averager state encoding, framer-shared
// symbol defaults, and width-generic I/Q pack/unpack helpers.
package ofdm_pkg;

  localparam int unsigned SYMBOL_LEN_DEFAULT                = 64;
  localparam int unsigned LONG_PREAMBLE_NUM_SYMBOLS_DEFAULT = 2;
  localparam int unsigned IQ_MAX_W                          = 64;

  typedef logic [IQ_MAX_W-1:0] iq_word_t;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCUM   = 2'd1,
    S_AVERAGE = 2'd2,
    S_PAYLOAD = 2'd3
  } state_t;

  function automatic iq_word_t iq_mask(int unsigned hw);
    return (iq_word_t'(1) << hw) - iq_word_t'(1);
  endfunction

  // I occupies the upper half of the sample, Q the lower half.
  function automatic iq_word_t iq_pack(iq_word_t i, iq_word_t q, int unsigned hw);
    return ((i & iq_mask(hw)) << hw) | (q & iq_mask(hw));
  endfunction

  function automatic iq_word_t iq_unpack_i(iq_word_t d, int unsigned hw);
    return (d >> hw) & iq_mask(hw);
  endfunction

  function automatic iq_word_t iq_unpack_q(iq_word_t d, int unsigned hw);
    return d & iq_mask(hw);
  endfunction

endpackage

// File: rtl/ofdm_iq_acc_ram.sv
// Per-sample I/Q accumulator storage: synchronous write, asynchronous read.
module ofdm_iq_acc_ram #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned DW    = 34,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ofdm_preamble_averager.sv
// Coherently averages the long-preamble symbols of each frame into one symbol
// and passes payload symbols through unchanged, behind one output register.
module ofdm_preamble_averager
  import ofdm_pkg::*;
#(
  parameter int unsigned WIDTH                     = 32,
  parameter int unsigned SYMBOL_LEN                = SYMBOL_LEN_DEFAULT,
  parameter int unsigned LONG_PREAMBLE_NUM_SYMBOLS = LONG_PREAMBLE_NUM_SYMBOLS_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_tdata,
  input  logic             i_tlast,
  input  logic             i_tvalid,
  output logic             i_tready,
  input  logic             i_sof,
  input  logic             i_eof,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tlast,
  output logic             o_tvalid,
  input  logic             o_tready,
  output logic             o_sof,
  output logic             o_eof,
  output logic             o_err,
  output logic [15:0]      o_drop_cnt
);

  localparam int unsigned HW = WIDTH / 2;
  localparam int unsigned K  = $clog2(LONG_PREAMBLE_NUM_SYMBOLS);
  localparam int unsigned AW = HW + K;
  localparam int unsigned CW = $clog2(SYMBOL_LEN);
  localparam int unsigned SW = K + 1;
  localparam logic [CW-1:0]        LAST_IDX     = CW'(SYMBOL_LEN - 1);
  localparam logic [SW-1:0]        ACC_LAST_SYM = SW'(LONG_PREAMBLE_NUM_SYMBOLS - 2);
  localparam logic signed [AW-1:0] RND          = AW'(1 << (K - 1));

  state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [SW-1:0] sym_cnt, sym_nxt;
  logic accept, last_pos, frame_err;

  logic signed [HW-1:0] in_i, in_q;
  logic signed [AW-1:0] ext_i, ext_q, acc_i, acc_q, sum_i, sum_q, rnd_i, rnd_q;
  logic [HW-1:0]        avg_i, avg_q;
  logic [WIDTH-1:0]     avg_data;

  logic            ram_we;
  logic [CW-1:0]   ram_waddr;
  logic [2*AW-1:0] ram_wdata, ram_rdata;

  logic             restart_c, err_c, drop_inc_c;
  logic             emit_c, emit_last_c, emit_sof_c, emit_eof_c;
  logic [WIDTH-1:0] emit_data_c;

  // Sample split and sign extension into accumulator precision.
  assign in_i  = HW'(iq_unpack_i(IQ_MAX_W'(i_tdata), HW));
  assign in_q  = HW'(iq_unpack_q(IQ_MAX_W'(i_tdata), HW));
  assign ext_i = {{K{in_i[HW-1]}}, in_i};
  assign ext_q = {{K{in_q[HW-1]}}, in_q};

  assign acc_i = ram_rdata[2*AW-1:AW];
  assign acc_q = ram_rdata[AW-1:0];
  assign sum_i = acc_i + ext_i;
  assign sum_q = acc_q + ext_q;
  // Round half up; the average of N in-range samples always fits HW bits.
  assign rnd_i = sum_i + RND;
  assign rnd_q = sum_q + RND;
  assign avg_i = HW'(rnd_i >>> K);
  assign avg_q = HW'(rnd_q >>> K);
  assign avg_data = WIDTH'(iq_pack(IQ_MAX_W'(avg_i), IQ_MAX_W'(avg_q), HW));

  assign i_tready  = (state == S_IDLE || state == S_ACCUM) ? 1'b1 : (o_tready | ~o_tvalid);
  assign accept    = i_tvalid & i_tready;
  assign last_pos  = (cnt == LAST_IDX);
  assign frame_err = accept & (i_tlast != last_pos) & (state == S_ACCUM || state == S_AVERAGE);

  ofdm_iq_acc_ram #(
    .DEPTH (SYMBOL_LEN),
    .DW    (2 * AW),
    .AW    (CW)
  ) u_acc_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (cnt),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (accept) begin
      case (state)
        S_IDLE:    if (i_sof) state_nxt = S_ACCUM;
        S_ACCUM: begin
          if (frame_err)                             state_nxt = i_sof ? S_ACCUM : S_IDLE;
          else if (last_pos && sym_cnt == ACC_LAST_SYM) state_nxt = S_AVERAGE;
        end
        S_AVERAGE: begin
          if (frame_err)     state_nxt = i_sof ? S_ACCUM : S_IDLE;
          else if (last_pos) state_nxt = S_PAYLOAD;
        end
        S_PAYLOAD: begin
          if (i_sof)                 state_nxt = S_ACCUM;
          else if (i_tlast && i_eof) state_nxt = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    ram_we      = 1'b0;
    ram_waddr   = cnt;
    ram_wdata   = {ext_i, ext_q};
    cnt_nxt     = cnt;
    sym_nxt     = sym_cnt;
    restart_c   = 1'b0;
    err_c       = 1'b0;
    drop_inc_c  = 1'b0;
    emit_c      = 1'b0;
    emit_data_c = i_tdata;
    emit_last_c = i_tlast;
    emit_sof_c  = 1'b0;
    emit_eof_c  = 1'b0;
    if (accept) begin
      case (state)
        S_IDLE: begin
          if (i_sof) restart_c  = 1'b1;
          else       drop_inc_c = 1'b1;
        end
        S_ACCUM: begin
          if (frame_err) begin
            err_c     = 1'b1;
            restart_c = i_sof;
            cnt_nxt   = '0;
            sym_nxt   = '0;
          end else begin
            ram_we  = 1'b1;
            if (sym_cnt != '0) ram_wdata = {sum_i, sum_q};
            cnt_nxt = cnt + CW'(1);
            if (last_pos) sym_nxt = sym_cnt + SW'(1);
          end
        end
        S_AVERAGE: begin
          // An erroring first beat has no partial symbol to close, so it is not emitted.
          emit_c      = ~frame_err | (cnt != '0);
          emit_data_c = avg_data;
          emit_sof_c  = (cnt == '0);
          emit_last_c = last_pos | frame_err;
          cnt_nxt     = cnt + CW'(1);
          if (frame_err) begin
            err_c     = 1'b1;
            restart_c = i_sof;
            cnt_nxt   = '0;
            sym_nxt   = '0;
          end
        end
        S_PAYLOAD: begin
          emit_c     = 1'b1;
          emit_eof_c = i_tlast & i_eof;
          if (i_sof) begin
            err_c       = 1'b1;
            restart_c   = 1'b1;
            emit_last_c = 1'b1;
            emit_eof_c  = 1'b1;
          end
        end
        default: ;
      endcase
    end
    if (restart_c) begin
      ram_we    = 1'b1;
      ram_waddr = '0;
      ram_wdata = {ext_i, ext_q};
      cnt_nxt   = CW'(1);
      sym_nxt   = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      sym_cnt    <= '0;
      o_err      <= 1'b0;
      o_drop_cnt <= '0;
    end else begin
      cnt     <= cnt_nxt;
      sym_cnt <= sym_nxt;
      o_err   <= err_c;
      if (drop_inc_c && o_drop_cnt != 16'hFFFF) o_drop_cnt <= o_drop_cnt + 16'd1;
    end
  end

  // Single output stage; emit only happens on an accepted beat, so the stage is free.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_tvalid <= 1'b0;
      o_tdata  <= '0;
      o_tlast  <= 1'b0;
      o_sof    <= 1'b0;
      o_eof    <= 1'b0;
    end else if (emit_c) begin
      o_tvalid <= 1'b1;
      o_tdata  <= emit_data_c;
      o_tlast  <= emit_last_c;
      o_sof    <= emit_sof_c;
      o_eof    <= emit_eof_c;
    end else if (o_tready) begin
      o_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ofdm_preamble_averager.sv
// Directed bench for ofdm_preamble_averager: averaging, rounding, backpressure,
// drop counting, framing errors, async reset, and a 4-symbol preamble instance.
module tb_ofdm_preamble_averager;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] i_tdata = '0;
  logic        i_tlast = 1'b0, i_tvalid = 1'b0, i_sof = 1'b0, i_eof = 1'b0;
  logic        i_tready;
  logic [31:0] o_tdata;
  logic        o_tlast, o_tvalid, o_sof, o_eof, o_err;
  logic        o_tready = 1'b1;
  logic [15:0] o_drop_cnt;

  logic [31:0] i4_tdata = '0;
  logic        i4_tlast = 1'b0, i4_tvalid = 1'b0, i4_sof = 1'b0, i4_eof = 1'b0;
  logic        i4_tready;
  logic [31:0] o4_tdata;
  logic        o4_tlast, o4_tvalid, o4_sof, o4_eof, o4_err;
  logic        o4_tready = 1'b1;
  logic [15:0] o4_drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int rdy_mode = 0;
  bit gap_en   = 1'b0;

  logic [34:0] got[$];
  logic [34:0] got4[$];
  logic [34:0] exp_q[$];
  int          err_total  = 0;
  int          stall_viol = 0;
  logic        stall_prev = 1'b0;
  logic [31:0] stall_data = '0;
  logic        stall_last = 1'b0;

  ofdm_preamble_averager dut (
    .clk(clk), .reset(reset),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
    .i_sof(i_sof), .i_eof(i_eof),
    .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
    .o_sof(o_sof), .o_eof(o_eof), .o_err(o_err), .o_drop_cnt(o_drop_cnt)
  );

  ofdm_preamble_averager #(.LONG_PREAMBLE_NUM_SYMBOLS(4)) dut4 (
    .clk(clk), .reset(reset),
    .i_tdata(i4_tdata), .i_tlast(i4_tlast), .i_tvalid(i4_tvalid), .i_tready(i4_tready),
    .i_sof(i4_sof), .i_eof(i4_eof),
    .o_tdata(o4_tdata), .o_tlast(o4_tlast), .o_tvalid(o4_tvalid), .o_tready(o4_tready),
    .o_sof(o4_sof), .o_eof(o4_eof), .o_err(o4_err), .o_drop_cnt(o4_drop_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (rdy_mode == 0)      o_tready = 1'b1;
    else if (rdy_mode == 1) o_tready = 1'($urandom_range(0, 1));
    else                    o_tready = 1'b0;
  end

  // Output monitor: records transfers and checks that stalled beats hold steady.
  always @(negedge clk) begin
    if (reset) begin
      stall_prev <= 1'b0;
    end else begin
      if (o_err) err_total <= err_total + 1;
      if (stall_prev && (!o_tvalid || o_tdata !== stall_data || o_tlast !== stall_last))
        stall_viol <= stall_viol + 1;
      stall_prev <= o_tvalid && !o_tready;
      stall_data <= o_tdata;
      stall_last <= o_tlast;
      if (o_tvalid && o_tready)   got.push_back({o_sof, o_eof, o_tlast, o_tdata});
      if (o4_tvalid && o4_tready) got4.push_back({o4_sof, o4_eof, o4_tlast, o4_tdata});
    end
  end

  task automatic check(string tag, logic [63:0] obs, logic [63:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [34:0] mk(logic [15:0] i, logic [15:0] q, logic sof, logic eof, logic last);
    return {sof, eof, last, i, q};
  endfunction

  task automatic send_beat(logic [31:0] d, logic last, logic sof, logic eof);
    bit ok = 1'b0;
    if (gap_en && $urandom_range(0, 2) == 0) begin
      i_tvalid = 1'b0;
      @(posedge clk); #1;
    end
    i_tdata = d; i_tlast = last; i_sof = sof; i_eof = eof; i_tvalid = 1'b1;
    for (int t = 0; t < 1000; t++) begin
      @(negedge clk);
      if (i_tready) begin ok = 1'b1; break; end
    end
    if (!ok) check("send_ready", 64'(i_tready), 64'd1);
    @(posedge clk); #1;
    i_tvalid = 1'b0;
  endtask

  task automatic send_sym(logic [15:0] i0, logic [15:0] q0, logic [15:0] ir, logic [15:0] qr, logic sof);
    for (int b = 0; b < 64; b++)
      send_beat((b == 0) ? {i0, q0} : {ir, qr}, b == 63, sof, 1'b0);
  endtask

  task automatic send_payload(int nsym, logic [15:0] ptag);
    for (int s = 0; s < nsym; s++)
      for (int b = 0; b < 64; b++) begin
        logic [31:0] d;
        logic last, eof;
        d    = {ptag + 16'(s * 64 + b), 16'hA000 + 16'(b)};
        last = (b == 63);
        eof  = (s == nsym - 1);
        send_beat(d, last, 1'b0, eof);
        exp_q.push_back({1'b0, last & eof, last, d});
      end
  endtask

  task automatic wait_out(int n);
    for (int t = 0; t < 4000 && got.size() < n; t++) @(negedge clk);
    repeat (8) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic compare_stream(string tag, int base);
    check({tag, "_count"}, 64'(got.size() - base), 64'(exp_q.size()));
    foreach (exp_q[i])
      check($sformatf("%s[%0d]", tag, i),
            (base + i < got.size()) ? 64'(got[base + i]) : {64{1'b1}}, 64'(exp_q[i]));
    exp_q.delete();
  endtask

  task automatic run_frame1(string tag, logic [15:0] ptag);
    int base = got.size();
    send_sym(16'd100, -16'd50, 16'd100, -16'd50, 1'b1);
    send_sym(16'd102, -16'd52, 16'd102, -16'd52, 1'b0);
    for (int b = 0; b < 64; b++) exp_q.push_back(mk(16'd101, -16'd51, b == 0, 1'b0, b == 63));
    send_payload(3, ptag);
    wait_out(base + 256);
    compare_stream(tag, base);
  endtask

  initial begin
    int base, err0;

    repeat (3) @(negedge clk);
    check("rst_tvalid", 64'(o_tvalid), 64'd0);
    check("rst_flags", 64'({o_tlast, o_sof, o_eof, o_err}), 64'd0);
    check("rst_drop", 64'(o_drop_cnt), 64'd0);
    check("rst_tready", 64'(i_tready), 64'd1);
    reset = 1'b0;
    @(posedge clk); #1;

    // Beats without sof in idle are dropped.
    base = got.size();
    for (int b = 0; b < 5; b++) send_beat(32'h1234_0000 + 32'(b), 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("drop_cnt", 64'(o_drop_cnt), 64'd5);
    check("drop_no_out", 64'(got.size() - base), 64'd0);
    check("drop_tvalid", 64'(o_tvalid), 64'd0);
    @(posedge clk); #1;

    err0 = err_total;
    run_frame1("frame1", 16'h1000);
    check("frame1_err", 64'(err_total - err0), 64'd0);

    // Rounding: (1,0)+(2,-1) -> (2,0); (-3,-1)+(0,0) -> (-1,0).
    base = got.size();
    send_sym(16'd1, 16'd0, -16'd3, -16'd1, 1'b1);
    send_sym(16'd2, -16'd1, 16'd0, 16'd0, 1'b0);
    for (int b = 0; b < 64; b++)
      exp_q.push_back((b == 0) ? mk(16'd2, 16'd0, 1'b1, 1'b0, 1'b0)
                               : mk(-16'd1, 16'd0, 1'b0, 1'b0, b == 63));
    send_payload(1, 16'h2000);
    wait_out(base + 128);
    compare_stream("round", base);

    // Random backpressure and input gaps must not change the stream.
    rdy_mode = 1; gap_en = 1'b1;
    run_frame1("stall", 16'h1000);
    rdy_mode = 0; gap_en = 1'b0;
    @(posedge clk); #1;

    // Early tlast in the first preamble symbol aborts the frame.
    err0 = err_total;
    base = got.size();
    for (int b = 0; b < 31; b++) send_beat({16'd7, 16'd7}, b == 30, b == 0, 1'b0);
    repeat (5) @(negedge clk);
    check("early_err", 64'(err_total - err0), 64'd1);
    check("early_no_out", 64'(got.size() - base), 64'd0);
    @(posedge clk); #1;
    run_frame1("after_err", 16'h3000);

    // Asynchronous reset while a payload beat is held in the output stage.
    send_sym(16'd100, -16'd50, 16'd100, -16'd50, 1'b1);
    send_sym(16'd102, -16'd52, 16'd102, -16'd52, 1'b0);
    wait_out(0);
    rdy_mode = 2;
    @(posedge clk); #1;
    send_beat(32'hCAFE_0001, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("hold_tvalid", 64'(o_tvalid), 64'd1);
    #2 reset = 1'b1;
    #1 check("async_rst_tvalid", 64'(o_tvalid), 64'd0);
    rdy_mode = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check("post_rst_drop", 64'(o_drop_cnt), 64'd0);
    run_frame1("post_rst", 16'h4000);

    // Four-symbol preamble: I=10..13 -> 12, Q=-10..-13 -> -11.
    for (int s = 0; s < 4; s++)
      for (int b = 0; b < 64; b++) begin
        i4_tdata = {16'(10 + s), 16'(-(10 + s))};
        i4_tlast = (b == 63); i4_sof = (s == 0); i4_eof = 1'b0; i4_tvalid = 1'b1;
        @(posedge clk); #1;
      end
    for (int b = 0; b < 64; b++) begin
      i4_tdata = {16'(b), 16'(b)};
      i4_tlast = (b == 63); i4_sof = 1'b0; i4_eof = 1'b1; i4_tvalid = 1'b1;
      @(posedge clk); #1;
    end
    i4_tvalid = 1'b0;
    for (int t = 0; t < 500 && got4.size() < 128; t++) @(negedge clk);
    repeat (4) @(negedge clk);
    check("n4_count", 64'(got4.size()), 64'd128);
    for (int b = 0; b < 128; b++) begin
      logic [34:0] e;
      e = (b < 64) ? mk(16'd12, -16'd11, b == 0, 1'b0, b == 63)
                   : mk(16'(b - 64), 16'(b - 64), 1'b0, b == 127, b == 127);
      check($sformatf("n4[%0d]", b), (b < got4.size()) ? 64'(got4[b]) : {64{1'b1}}, 64'(e));
    end

    check("stall_stable", 64'(stall_viol), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
